// File: rtl/kyber_pkg.sv
// Shared Kyber accelerator constants, default hash widths and the hash
// scheduler state encoding.
package kyber_pkg;
  localparam int KYBER_N    = 256;
  localparam int HASH_IN_W  = 2 * KYBER_N;
  localparam int HASH_OUT_W = 2 * KYBER_N;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} hash_sched_state_t;

  // Width of an index into n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found scanning
// upward from i_ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import kyber_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  int                   w_pos;
  int                   w_sum;
  logic                 w_hit;

  // Doubling the vector turns the wrap-around scan into a plain shift.
  assign w_req_dbl = {i_req, i_req};
  assign w_rot     = NUM_REQ'(w_req_dbl >> i_ptr);

  always_comb begin
    w_pos = 0;
    w_hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos = k;
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = int'(i_ptr) + w_pos;
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    o_any = w_hit;
    o_idx = w_hit ? IDX_W'(w_sum) : '0;
    o_gnt = w_hit ? (NUM_REQ'(1) << w_sum) : '0;
  end
endmodule

// File: rtl/hash_scheduler.sv
// Round-robin scheduler sharing one SHA3 core among NUM_REQ requesters.
// Define HASH_SCHED_TIMEOUT_EN to add the WAIT watchdog and the resp_err output.
module hash_scheduler
  import kyber_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int IN_WIDTH  = HASH_IN_W,
  parameter int OUT_WIDTH = HASH_OUT_W
`ifdef HASH_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [OUT_WIDTH-1:0]        resp_data,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic                        core_start,
  output logic [IN_WIDTH-1:0]         core_in,
  input  logic                        core_done,
  input  logic [OUT_WIDTH-1:0]        core_out,
  output logic                        busy
`ifdef HASH_SCHED_TIMEOUT_EN
  ,
  output logic                        resp_err
`endif
);
  // state | meaning
  // IDLE  | arbitrate; the granted request is latched on this edge
  // ISSUE | core_start high for this single cycle
  // WAIT  | wait for core_done (or watchdog expiry when enabled)
  // RESP  | digest held for the owner until its resp_ready
  localparam int IDX_W = idx_w(NUM_REQ);

  hash_sched_state_t    r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, r_owner;
  logic [IN_WIDTH-1:0]  r_core_in;
  logic [OUT_WIDTH-1:0] r_resp_data;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_gnt_any;
  logic                 w_release;
  logic                 w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  assign w_release = resp_ready[r_owner];

`ifdef HASH_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_resp_err;

  // Down-counter loaded on the way into WAIT; expiry at terminal count zero.
  assign w_timeout = (r_state == WAIT) && !core_done && (r_wdog == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog     <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == ISSUE) r_wdog <= WD_W'(TIMEOUT - 1);
      else if (r_state == WAIT && r_wdog != '0) r_wdog <= r_wdog - WD_W'(1);
      if (r_state == WAIT && core_done) r_resp_err <= 1'b0;
      else if (w_timeout) r_resp_err <= 1'b1;
      else if (r_state == RESP && w_release) r_resp_err <= 1'b0;
    end
  end

  assign resp_err = r_resp_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_any) begin
          req_ready   = w_gnt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (core_done || w_timeout) w_state_nxt = RESP;
      RESP:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_core_in   <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_owner   <= w_gnt_idx;
            r_core_in <= req_data[w_gnt_idx*IN_WIDTH +: IN_WIDTH];
          end
        end
        WAIT: begin
          if (core_done) r_resp_data <= core_out;
          else if (w_timeout) r_resp_data <= '0;
        end
        RESP: begin
          if (w_release)
            r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign resp_data  = r_resp_data;
  assign core_start = (r_state == ISSUE);
  assign core_in    = r_core_in;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_hash_scheduler.sv
// Self-checking bench for hash_scheduler: directed scenarios plus randomized
// traffic against a round-robin reference model and a behavioural SHA3 core.
module tb_hash_scheduler;
  import kyber_pkg::*;

  localparam int N  = 3;
  localparam int W  = HASH_IN_W;
  localparam int OW = HASH_OUT_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [OW-1:0]  resp_data;
  logic [N-1:0]   resp_ready = '0;
  logic           core_start;
  logic [W-1:0]   core_in;
  logic           core_done;
  logic [OW-1:0]  core_out;
  logic           busy;
`ifdef HASH_SCHED_TIMEOUT_EN
  logic           resp_err;
`endif

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;

  // Behavioural core: digest = ~message, done core_lat+1 edges after start.
  bit            core_auto = 1'b0;
  int            core_lat = 3;
  int            model_cnt = 0;
  logic          model_done = 1'b0;
  logic [OW-1:0] model_out = '0;
  logic          spur_done = 1'b0;
  logic [OW-1:0] spur_out = '0;

  assign core_done = model_done | spur_done;
  assign core_out  = spur_done ? spur_out : model_out;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_auto && core_start) begin
      model_cnt <= core_lat;
      model_out <= ~core_in;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) model_done <= 1'b1;
    end
  end

  hash_scheduler #(
    .NUM_REQ(N), .IN_WIDTH(W), .OUT_WIDTH(OW)
`ifdef HASH_SCHED_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .core_start(core_start), .core_in(core_in),
    .core_done(core_done), .core_out(core_out), .busy(busy)
`ifdef HASH_SCHED_TIMEOUT_EN
    , .resp_err(resp_err)
`endif
  );

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] slice(input int i);
    return req_data[i*W +: W];
  endfunction

  // Reference arbitration: first requester at or after ptr, modulo N.
  function automatic int ref_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0 && i < N) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == onehot(i)) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid !== '0) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL resp_wait: resp_valid stayed %b for 100 cycles, required a response", resp_valid);
    end
  endtask

  task automatic accept(input int owner);
    step();
    resp_ready = onehot(owner);
    step();
    resp_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (core_start !== 1'b0) begin fails++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    tests++; if (core_in !== '0) begin fails++; $display("FAIL reset_core_in: got %h want 0", core_in); end
    tests++; if (resp_valid !== '0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_data !== '0) begin fails++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
`ifdef HASH_SCHED_TIMEOUT_EN
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
`endif
    step();
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    int done_cyc, resp_cyc;
    d = {(W/8){8'hA5}};
    core_auto = 1'b1;
    core_lat = 5;
    step();
    req_data = '0;
    req_data[1*W +: W] = d;
    req_valid = 3'b010;
    @(negedge clk);
    tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL single_req_ready: got %b want 010", req_ready); end
    step();
    req_valid = '0;
    @(negedge clk);
    tests++; if (core_start !== 1'b1) begin fails++; $display("FAIL single_core_start: got %b want 1", core_start); end
    tests++; if (core_in !== d) begin fails++; $display("FAIL single_core_in: got %h want %h", core_in, d); end
    @(negedge clk);
    tests++; if (core_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b want 0", core_start); end
    done_cyc = -1;
    resp_cyc = -1;
    for (int c = 0; c < 40 && resp_cyc < 0; c++) begin
      if (resp_valid !== '0) resp_cyc = c;
      else if (core_done === 1'b1) done_cyc = c;
      if (resp_cyc < 0) @(negedge clk);
    end
    tests++; if (resp_cyc < 0 || resp_cyc != done_cyc + 1) begin fails++; $display("FAIL single_latency: resp at %0d done at %0d want resp=done+1", resp_cyc, done_cyc); end
    tests++; if (resp_valid !== 3'b010) begin fails++; $display("FAIL single_resp_valid: got %b want 010", resp_valid); end
    tests++; if (resp_data !== ~d) begin fails++; $display("FAIL single_resp_data: got %h want %h", resp_data, ~d); end
    step();
    resp_ready = 3'b010;
    @(negedge clk);
    tests++; if (resp_valid !== 3'b010) begin fails++; $display("FAIL single_hold_to_edge: got %b want 010", resp_valid); end
    step();
    resp_ready = '0;
    @(negedge clk);
    tests++; if (resp_valid !== '0 || busy !== 1'b0) begin fails++; $display("FAIL single_release: resp_valid %b busy %b want 000 0", resp_valid, busy); end
    exp_ptr = 2;
  endtask

  task automatic test_contention();
    int exp_order[4];
    int obs[4];
    int n_obs, cyc, p;
    bit bad_ready;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ptr = 0;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      exp_order[i] = ref_grant(3'b111, p);
      p = (exp_order[i] + 1) % N;
    end
    for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_word();
    core_auto = 1'b1;
    core_lat = 2;
    n_obs = 0;
    cyc = 0;
    bad_ready = 1'b0;
    req_valid = '1;
    resp_ready = '1;
    while (n_obs < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && req_ready !== '0) bad_ready = 1'b1;
      if (resp_valid !== '0 && n_obs > 0) begin
        tests++;
        if (resp_valid !== onehot(exp_order[n_obs-1]) || resp_data !== ~slice(exp_order[n_obs-1])) begin
          fails++;
          $display("FAIL contention_resp: resp_valid %b want %b", resp_valid, onehot(exp_order[n_obs-1]));
        end
      end
      if (busy === 1'b0 && req_ready !== '0) begin
        obs[n_obs] = idx_of(req_ready);
        n_obs++;
      end
    end
    tests++; if (n_obs != 4) begin fails++; $display("FAIL contention_grants: saw %0d grants want 4", n_obs); end
    for (int i = 0; i < n_obs; i++) begin
      tests++;
      if (obs[i] != exp_order[i]) begin fails++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, obs[i], exp_order[i]); end
    end
    tests++; if (bad_ready) begin fails++; $display("FAIL contention_ready_busy: req_ready seen while busy=1, want none"); end
    step();
    req_valid = '0;
    resp_ready = '0;
    wait_resp();
    accept(exp_order[3]);
    exp_ptr = (exp_order[3] + 1) % N;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    int g;
    core_auto = 1'b1;
    core_lat = 3;
    d = rand_word();
    req_data[2*W +: W] = d;
    g = ref_grant(3'b100, exp_ptr);
    step();
    req_valid = 3'b100;
    @(negedge clk);
    tests++; if (req_ready !== onehot(g)) begin fails++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g)); end
    step();
    req_valid = '0;
    wait_resp();
    step();
    resp_ready = 3'b011;
    req_valid = 3'b011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (resp_valid !== 3'b100 || req_ready !== '0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: resp_valid %b req_ready %b want 100 000", c, resp_valid, req_ready);
      end
      tests++; if (resp_data !== ~d) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", c, resp_data, ~d); end
      step();
    end
    resp_ready = 3'b100;
    @(negedge clk);
    tests++; if (resp_valid !== 3'b100) begin fails++; $display("FAIL bp_before_release: got %b want 100", resp_valid); end
    step();
    resp_ready = '0;
    exp_ptr = (g + 1) % N;
    g = ref_grant(3'b011, exp_ptr);
    @(negedge clk);
    tests++; if (req_ready !== onehot(g)) begin fails++; $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(g)); end
    step();
    req_valid = '0;
    wait_resp();
    accept(g);
    exp_ptr = (g + 1) % N;
  endtask

  task automatic test_spurious();
    logic [OW-1:0] v;
    int g;
    core_auto = 1'b0;
    step();
    spur_out = rand_word();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    @(negedge clk);
    tests++; if (resp_valid !== '0 || busy !== 1'b0) begin fails++; $display("FAIL spur_idle: resp_valid %b busy %b want 000 0", resp_valid, busy); end
    req_data[0*W +: W] = rand_word();
    g = ref_grant(3'b001, exp_ptr);
    step();
    req_valid = 3'b001;
    @(negedge clk);
    tests++; if (req_ready !== onehot(g)) begin fails++; $display("FAIL spur_grant: got %b want %b", req_ready, onehot(g)); end
    step();
    req_valid = '0;
    spur_done = 1'b1;
    @(negedge clk);
    tests++; if (core_start !== 1'b1) begin fails++; $display("FAIL spur_issue: core_start %b want 1", core_start); end
    step();
    spur_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (resp_valid !== '0 || busy !== 1'b1 || core_start !== 1'b0) begin
        fails++;
        $display("FAIL spur_wait[%0d]: resp_valid %b busy %b start %b want 000 1 0", c, resp_valid, busy, core_start);
      end
    end
    v = rand_word();
    step();
    spur_out = v;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    @(negedge clk);
    tests++; if (resp_valid !== onehot(g)) begin fails++; $display("FAIL spur_real_done: resp_valid %b want %b", resp_valid, onehot(g)); end
    tests++; if (resp_data !== v) begin fails++; $display("FAIL spur_real_data: got %h want %h", resp_data, v); end
    accept(g);
    exp_ptr = (g + 1) % N;
  endtask

  task automatic test_mid_reset();
    core_auto = 1'b0;
    req_data[1*W +: W] = rand_word();
    step();
    req_valid = 3'b010;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    tests++; if (busy !== 1'b1 || core_start !== 1'b0) begin fails++; $display("FAIL mrst_in_wait: busy %b start %b want 1 0", busy, core_start); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mrst_busy: got %b want 0", busy); end
    tests++; if (core_start !== 1'b0) begin fails++; $display("FAIL mrst_core_start: got %b want 0", core_start); end
    tests++; if (core_in !== '0) begin fails++; $display("FAIL mrst_core_in: got %h want 0", core_in); end
    tests++; if (resp_valid !== '0) begin fails++; $display("FAIL mrst_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_data !== '0) begin fails++; $display("FAIL mrst_resp_data: got %h want 0", resp_data); end
    exp_ptr = 0;
    step();
    spur_out = rand_word();
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    @(negedge clk);
    tests++; if (resp_valid !== '0 || busy !== 1'b0) begin fails++; $display("FAIL mrst_late_done: resp_valid %b busy %b want 000 0", resp_valid, busy); end
    for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_word();
    step();
    req_valid = '1;
    @(negedge clk);
    tests++; if (req_ready !== onehot(ref_grant(3'b111, exp_ptr))) begin fails++; $display("FAIL mrst_next_grant: got %b want %b", req_ready, onehot(ref_grant(3'b111, exp_ptr))); end
    step();
    req_valid = '0;
    core_auto = 1'b1;
    core_lat = 2;
    wait_resp();
    tests++; if (resp_data !== ~slice(0)) begin fails++; $display("FAIL mrst_next_data: got %h want %h", resp_data, ~slice(0)); end
    accept(0);
    exp_ptr = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    int g, hold;
    core_auto = 1'b1;
    for (int it = 0; it < 30; it++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_word();
      core_lat = $urandom_range(1, 5);
      hold = $urandom_range(0, 3);
      g = ref_grant(v, exp_ptr);
      step();
      req_valid = v;
      @(negedge clk);
      tests++; if (req_ready !== onehot(g)) begin fails++; $display("FAIL rand_grant[%0d]: got %b want %b (req %b)", it, req_ready, onehot(g), v); end
      step();
      req_valid = '0;
      @(negedge clk);
      tests++; if (core_start !== 1'b1 || core_in !== slice(g)) begin fails++; $display("FAIL rand_issue[%0d]: start %b core_in %h", it, core_start, core_in); end
      wait_resp();
      tests++; if (resp_valid !== onehot(g)) begin fails++; $display("FAIL rand_resp_valid[%0d]: got %b want %b", it, resp_valid, onehot(g)); end
      tests++; if (resp_data !== ~slice(g)) begin fails++; $display("FAIL rand_resp_data[%0d]: got %h want %h", it, resp_data, ~slice(g)); end
`ifdef HASH_SCHED_TIMEOUT_EN
      tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL rand_resp_err[%0d]: got %b want 0", it, resp_err); end
`endif
      repeat (hold) step();
      accept(g);
      exp_ptr = (g + 1) % N;
    end
  endtask

`ifdef HASH_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int g, n;
    bit seen;
    core_auto = 1'b0;
    g = ref_grant(3'b001, exp_ptr);
    step();
    req_valid = 3'b001;
    step();
    req_valid = '0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid !== '0) seen = 1'b1;
      else if (busy === 1'b1 && core_start === 1'b0) n++;
    end
    tests++; if (!seen || n != 8) begin fails++; $display("FAIL to_wait_cycles: got %0d (seen %b) want 8", n, seen); end
    tests++; if (resp_valid !== onehot(g)) begin fails++; $display("FAIL to_resp_valid: got %b want %b", resp_valid, onehot(g)); end
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL to_resp_err: got %b want 1", resp_err); end
    tests++; if (resp_data !== '0) begin fails++; $display("FAIL to_resp_data: got %h want 0", resp_data); end
    accept(g);
    @(negedge clk);
    tests++; if (resp_valid !== '0 || resp_err !== 1'b0) begin fails++; $display("FAIL to_clear: resp_valid %b resp_err %b want 000 0", resp_valid, resp_err); end
    exp_ptr = (g + 1) % N;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_spurious();
    test_mid_reset();
    test_random();
`ifdef HASH_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "time limit");
  end
endmodule
